// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 16-bit ALU between NUM_REQ requesters, with a grant lock for carry chains.
// Optional macro ALU_ARB_CARRY_RESTORE_EN adds per-requester carry save/restore through a RESTORE state.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [3*NUM_REQ-1:0]  req_op,
  input  logic [4*NUM_REQ-1:0]  req_alu_op,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [2:0]            alu_op,
  output logic [3:0]            alu_alu_op,
  output logic [15:0]           alu_s_1,
  output logic [15:0]           alu_s_2,
  input  logic [15:0]           alu_result,
  input  logic [3:0]            alu_flags,
  output logic [IDX_W-1:0]      owner,
  output logic                  locked
);
  localparam int NP = 1 << IDX_W;
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  // Padded to 2**IDX_W entries so an IDX_W-bit index is always in range.
  logic        valid_a [NP];
  logic        lock_a  [NP];
  logic [2:0]  op_a    [NP];
  logic [3:0]  aop_a   [NP];
  logic [15:0] a_a     [NP];
  logic [15:0] b_a     [NP];

  logic [IDX_W-1:0]   rr_q, owner_q;
  logic               locked_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [15:0]        rsp_result_q;

  logic               win_valid_s, grant_s;
  logic [IDX_W-1:0]   win_idx_s, next_rr_s;
  logic [NUM_REQ-1:0] grant_vec_s;

`ifdef ALU_ARB_CARRY_RESTORE_EN
  typedef enum logic {ARB = 1'b0, RESTORE = 1'b1} state_e;
  localparam logic [IDX_W:0] SRC_NONE = {1'b1, {IDX_W{1'b0}}};

  state_e           state_q, state_d;
  logic             held_q, held_d, restore_s;
  logic [IDX_W-1:0] held_idx_q, held_idx_d;
  logic [IDX_W:0]   last_c_src_q, last_c_src_d;
  logic             saved_c_q [NP];

  function automatic logic is_carry_op(input logic [2:0] op, input logic [3:0] sub);
    is_carry_op = (op == 3'b000) &&
                  ((sub == 4'b0010) || (sub == 4'b0100) || (sub == 4'b1110) || (sub == 4'b1111));
  endfunction
`endif

  // Unflatten the per-requester buses.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      valid_a[i] = 1'b0;
      lock_a[i]  = 1'b0;
      op_a[i]    = 3'b000;
      aop_a[i]   = 4'b0000;
      a_a[i]     = 16'h0000;
      b_a[i]     = 16'h0000;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_a[i] = req_valid[i];
      lock_a[i]  = req_lock[i];
      op_a[i]    = req_op[3*i +: 3];
      aop_a[i]   = req_alu_op[4*i +: 4];
      a_a[i]     = req_a[16*i +: 16];
      b_a[i]     = req_b[16*i +: 16];
    end
  end

  // Pick the winner: held restore target, else the lock owner, else round-robin from rr_q.
  always_comb begin
    logic [IDX_W:0] sum_v;
    sum_v       = '0;
    win_valid_s = 1'b0;
    win_idx_s   = '0;
`ifdef ALU_ARB_CARRY_RESTORE_EN
    if (held_q && valid_a[held_idx_q]) begin
      win_valid_s = 1'b1;
      win_idx_s   = held_idx_q;
    end else
`endif
    if (locked_q) begin
      win_valid_s = valid_a[owner_q];
      win_idx_s   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum_v = {1'b0, rr_q} + (IDX_W+1)'(k);
        sum_v = (sum_v >= NUM_REQ_W) ? (sum_v - NUM_REQ_W) : sum_v;
        if (!win_valid_s && valid_a[sum_v[IDX_W-1:0]]) begin
          win_valid_s = 1'b1;
          win_idx_s   = sum_v[IDX_W-1:0];
        end else begin
          win_valid_s = win_valid_s;
        end
      end
    end
  end

  // Issue decision and ALU drive; the idle op (0 + 0) leaves the ALU carry at 0.
  always_comb begin
    grant_s    = win_valid_s;
    alu_op     = 3'b000;
    alu_alu_op = 4'b0001;
    alu_s_1    = 16'h0000;
    alu_s_2    = 16'h0000;
`ifdef ALU_ARB_CARRY_RESTORE_EN
    restore_s    = 1'b0;
    state_d      = ARB;
    held_d       = 1'b0;
    held_idx_d   = held_idx_q;
    if (state_q == RESTORE) begin
      grant_s   = 1'b0;
      restore_s = 1'b1;
      held_d    = 1'b1;
    end else if (win_valid_s && is_carry_op(op_a[win_idx_s], aop_a[win_idx_s]) &&
                 (last_c_src_q != {1'b0, win_idx_s})) begin
      grant_s    = 1'b0;
      state_d    = RESTORE;
      held_idx_d = win_idx_s;
    end else begin
      state_d = ARB;
    end
`endif
    if (grant_s) begin
      alu_op     = op_a[win_idx_s];
      alu_alu_op = aop_a[win_idx_s];
      alu_s_1    = a_a[win_idx_s];
      alu_s_2    = b_a[win_idx_s];
    end
`ifdef ALU_ARB_CARRY_RESTORE_EN
    // 0xFFFF + saved_c carries out exactly when saved_c is 1.
    else if (restore_s) begin
      alu_s_1 = 16'hFFFF;
      alu_s_2 = {15'b0, saved_c_q[held_idx_q]};
    end
`endif
    else begin
      alu_op = 3'b000;
    end
`ifdef ALU_ARB_CARRY_RESTORE_EN
    if (grant_s) begin
      last_c_src_d = {1'b0, win_idx_s};
    end else if (restore_s) begin
      last_c_src_d = {1'b0, held_idx_q};
    end else begin
      last_c_src_d = SRC_NONE;
    end
`endif
  end

  assign next_rr_s   = (win_idx_s == IDX_W'(NUM_REQ-1)) ? '0 : (win_idx_s + IDX_W'(1));
  assign grant_vec_s = grant_s ? (NUM_REQ'(1) << win_idx_s) : '0;

  // Arbitration and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= '0;
      owner_q      <= '0;
      locked_q     <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= 16'h0000;
    end else begin
      rsp_valid_q <= grant_vec_s;
      if (grant_s) begin
        rr_q         <= next_rr_s;
        owner_q      <= win_idx_s;
        locked_q     <= lock_a[win_idx_s];
        rsp_result_q <= alu_result;
      end
    end
  end

`ifdef ALU_ARB_CARRY_RESTORE_EN
  // Restore FSM, carry-source tracking and per-requester saved carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      held_q       <= 1'b0;
      held_idx_q   <= '0;
      last_c_src_q <= SRC_NONE;
      for (int i = 0; i < NP; i++) saved_c_q[i] <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      held_idx_q   <= held_idx_d;
      last_c_src_q <= last_c_src_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid_q[i]) saved_c_q[i] <= alu_flags[0];
      end
    end
  end
`endif

  assign req_ready  = grant_vec_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = alu_flags;
  assign owner      = owner_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small reference ALU and a response scoreboard queue.
module tb_alu_arbiter;
  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_lock, rsp_valid;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [4*NUM_REQ-1:0]  req_alu_op;
  logic [16*NUM_REQ-1:0] req_a, req_b;
  logic [15:0]           rsp_result, alu_s_1, alu_s_2, alu_result;
  logic [3:0]            rsp_flags, alu_alu_op, alu_flags, nf_s;
  logic [2:0]            alu_op;
  logic [IDX_W-1:0]      owner;
  logic                  locked;
  logic [16:0]           sum_s;
  logic                  cin_s;

  int checks = 0;
  int errors = 0;
  logic [21:0] sb [$];
  logic [21:0] exp_v;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_op(req_op), .req_alu_op(req_alu_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_op(alu_op), .alu_alu_op(alu_alu_op), .alu_s_1(alu_s_1), .alu_s_2(alu_s_2),
    .alu_result(alu_result), .alu_flags(alu_flags), .owner(owner), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference ALU: add (000/0001), add-with-carry (000/0010); flags {O,S,Z,C} registered.
  always_comb begin
    cin_s      = (alu_op == 3'b000 && alu_alu_op == 4'b0010) ? alu_flags[0] : 1'b0;
    sum_s      = {1'b0, alu_s_1} + {1'b0, alu_s_2} + {16'h0000, cin_s};
    alu_result = sum_s[15:0];
    nf_s       = {(alu_s_1[15] == alu_s_2[15]) && (sum_s[15] != alu_s_1[15]),
                  sum_s[15], (sum_s[15:0] == 16'h0000), sum_s[16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_flags <= 4'h0;
    else        alu_flags <= nf_s;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic lk, input logic [2:0] op,
                         input logic [3:0] aop, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]         = v;
    req_lock[i]          = lk;
    req_op[3*i +: 3]     = op;
    req_alu_op[4*i +: 4] = aop;
    req_a[16*i +: 16]    = a;
    req_b[16*i +: 16]    = b;
  endtask

  task automatic clr_req(input int i);
    set_req(i, 1'b0, 1'b0, 3'b000, 4'b0000, 16'h0000, 16'h0000);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rsp_valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {62'b0, rsp_valid}, 64'h0);
      end else begin
        exp_v = sb.pop_front();
        chk("rsp", {42'b0, rsp_valid, rsp_result, rsp_flags}, {42'b0, exp_v});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    clr_req(0);
    clr_req(1);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {62'b0, req_ready}, 64'h0);
    chk("rst_rsp_valid", {62'b0, rsp_valid}, 64'h0);
    chk("rst_result", {48'b0, rsp_result}, 64'h0);
    chk("rst_owner", {62'b0, owner}, 64'h0);
    chk("rst_locked", {63'b0, locked}, 64'h0);
    chk("rst_alu_idle", {25'b0, alu_op, alu_alu_op, alu_s_1, alu_s_2}, {25'b0, 3'b000, 4'b0001, 32'h0});
    rst_n = 1'b1;

    // Idle: three cycles with nothing valid.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_alu", {25'b0, alu_op, alu_alu_op, alu_s_1, alu_s_2}, {25'b0, 3'b000, 4'b0001, 32'h0});
      chk("idle_ready", {62'b0, req_ready}, 64'h0);
      next_cycle();
    end
    chk("idle_flags", {60'b0, alu_flags}, 64'h2);

    // Single request from r0, then one from r1 (leaves rr pointer at 0).
    set_req(0, 1'b1, 1'b0, 3'b000, 4'b0001, 16'h1234, 16'h0001);
    sb.push_back({2'b01, 16'h1235, 4'h0});
    @(negedge clk);
    chk("single_r0_ready", {62'b0, req_ready}, 64'h1);
    next_cycle();
    clr_req(0);
    set_req(1, 1'b1, 1'b0, 3'b000, 4'b0001, 16'h7FFF, 16'h0001);
    sb.push_back({2'b10, 16'h8000, 4'hC});
    @(negedge clk);
    chk("single_r1_ready", {62'b0, req_ready}, 64'h2);
    next_cycle();
    clr_req(1);

    // Contention: both valid, grants alternate r0, r1.
    set_req(0, 1'b1, 1'b0, 3'b000, 4'b0001, 16'h0010, 16'h0001);
    set_req(1, 1'b1, 1'b0, 3'b000, 4'b0001, 16'h8000, 16'h8000);
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) sb.push_back({2'b01, 16'h0011, 4'h0});
      else            sb.push_back({2'b10, 16'h0000, 4'hB});
      @(negedge clk);
      chk("contend_ready", {62'b0, req_ready}, (c % 2 == 0) ? 64'h1 : 64'h2);
      next_cycle();
    end
    clr_req(0);

    // Lock chain: r0 add with lock, then addc without lock; r1 waits.
    set_req(0, 1'b1, 1'b1, 3'b000, 4'b0001, 16'hFFFF, 16'h0001);
    sb.push_back({2'b01, 16'h0000, 4'h3});
    @(negedge clk);
    chk("lock_a_ready", {62'b0, req_ready}, 64'h1);
    next_cycle();
    set_req(0, 1'b1, 1'b0, 3'b000, 4'b0010, 16'h0000, 16'h0000);
    sb.push_back({2'b01, 16'h0001, 4'h0});
    @(negedge clk);
    chk("lock_b_ready", {62'b0, req_ready}, 64'h1);
    chk("lock_b_locked", {63'b0, locked}, 64'h1);
    next_cycle();
    clr_req(0);
    sb.push_back({2'b10, 16'h0000, 4'hB});
    @(negedge clk);
    chk("lock_c_ready", {62'b0, req_ready}, 64'h2);
    chk("lock_c_locked", {63'b0, locked}, 64'h0);
    next_cycle();
    clr_req(1);

    // Carry interleave: r0 sets C=1, r1 clears it, r0 addc consumes carry.
    set_req(0, 1'b1, 1'b0, 3'b000, 4'b0001, 16'hFFFF, 16'h0001);
    sb.push_back({2'b01, 16'h0000, 4'h3});
    @(negedge clk);
    chk("carry_r0_ready", {62'b0, req_ready}, 64'h1);
    next_cycle();
    clr_req(0);
    set_req(1, 1'b1, 1'b0, 3'b000, 4'b0001, 16'h0001, 16'h0001);
    sb.push_back({2'b10, 16'h0002, 4'h0});
    @(negedge clk);
    chk("carry_r1_ready", {62'b0, req_ready}, 64'h2);
    next_cycle();
    clr_req(1);
    set_req(0, 1'b1, 1'b0, 3'b000, 4'b0010, 16'h0000, 16'h0000);
`ifdef ALU_ARB_CARRY_RESTORE_EN
    @(negedge clk);
    chk("restore_ready", {62'b0, req_ready}, 64'h0);
    chk("restore_alu", {32'b0, alu_s_1, alu_s_2}, {32'b0, 16'hFFFF, 16'h0001});
    next_cycle();
    sb.push_back({2'b01, 16'h0001, 4'h0});
    @(negedge clk);
    chk("restore_issue_ready", {62'b0, req_ready}, 64'h1);
    next_cycle();
`else
    sb.push_back({2'b01, 16'h0000, 4'h2});
    @(negedge clk);
    chk("addc_ready", {62'b0, req_ready}, 64'h1);
    next_cycle();
`endif
    clr_req(0);

    // Reset while r1 holds the lock; in-flight response is dropped.
    set_req(1, 1'b1, 1'b1, 3'b000, 4'b0001, 16'h7FFF, 16'h0001);
    @(negedge clk);
    chk("rstlock_ready", {62'b0, req_ready}, 64'h2);
    next_cycle();
    chk("rstlock_locked", {63'b0, locked}, 64'h1);
    chk("rstlock_owner", {62'b0, owner}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rstlock_locked_clr", {63'b0, locked}, 64'h0);
    chk("rstlock_rsp_clr", {62'b0, rsp_valid}, 64'h0);
    set_req(0, 1'b1, 1'b0, 3'b000, 4'b0001, 16'h0010, 16'h0001);
    set_req(1, 1'b1, 1'b0, 3'b000, 4'b0001, 16'h8000, 16'h8000);
    next_cycle();
    rst_n = 1'b1;
    sb.push_back({2'b01, 16'h0011, 4'h0});
    @(negedge clk);
    chk("post_rst_ready", {62'b0, req_ready}, 64'h1);
    next_cycle();
    clr_req(0);
    clr_req(1);
    repeat (2) next_cycle();
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 16-bit ALU (op/alu_op/s_1/s_2 in; combinational result, flags {O,S,Z,C} registered at posedge) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready request handshake, 1-cycle response carrying result plus flags, and a lock for multi-word carry chains.
- Sits between the core's issuing units (e.g. execute stage, address unit) and the ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); per-requester buses are flattened, requester i in slice i.
- IDX_W, 2, width of owner index; must satisfy 2**IDX_W >= NUM_REQ.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_lock  in  NUM_REQ  keep grant after this transaction
- req_op  in  3*NUM_REQ  ALU op field
- req_alu_op  in  4*NUM_REQ  ALU sub-op field
- req_a  in  16*NUM_REQ  operand s_1
- req_b  in  16*NUM_REQ  operand s_2
- rsp_valid  out  NUM_REQ  response valid, one-hot
- rsp_result  out  16  registered result, shared bus
- rsp_flags  out  4  flags {O,S,Z,C} for the response
- alu_op  out  3  to ALU op
- alu_alu_op  out  4  to ALU alu_op
- alu_s_1  out  16  to ALU s_1
- alu_s_2  out  16  to ALU s_2
- alu_result  in  16  from ALU result
- alu_flags  in  4  from ALU flags
- owner  out  IDX_W  current/last granted requester
- locked  out  1  lock held

Behaviour:
- Reset: req_ready=0, rsp_valid=0, rsp_result=0, owner=0, locked=0, rr pointer=0, FSM=ARB; ALU driven with the idle op.
- Idle op, whenever no request is issued: op=000, alu_op=0001, s_1=s_2=0, so the ALU carry becomes 0.
- FSM ARB, unlocked:
  - Grant the first valid requester scanning from rr pointer upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; the request's fields drive the ALU that cycle.
  - After a grant, rr pointer = g+1 mod NUM_REQ.
- FSM ARB, locked:
  - Only the owner may be granted; other requesters are held with ready=0.
  - If the owner is not valid, the idle op is driven. The lock persists and the carry is clobbered; the owner must issue back-to-back when carry matters.
- Lock set/clear:
  - Accepted transaction with req_lock=1 sets locked=1 and owner=g.
  - Accepted transaction with req_lock=0 clears locked.
- Response timing:
  - Accept in cycle N gives rsp_valid[g]=1 in cycle N+1, for exactly one cycle.
  - rsp_result = alu_result registered at the N edge.
  - rsp_flags = alu_flags passed through live in N+1; the ALU registered them at the same edge.
- No backpressure on responses.
- Throughput: one accept per cycle. Back-to-back accepts to different requesters are legal.
- Carry-consuming ops (op=000, alu_op in {0010,0100,1110,1111}) consume the ALU's current carry with no correction unless the optional feature is enabled.
- Fields of an unaccepted request must hold stable while req_valid=1. Dropping valid before acceptance is legal; nothing is issued.
- Mid-operation reset: all state clears asynchronously and any pending response is lost. After release, the first grant goes to requester 0 if valid.
- owner output: reflects the last granted requester.

Optional Feature:
- Macro: ALU_ARB_CARRY_RESTORE_EN
- Defined:
  - A per-requester saved carry is captured from alu_flags[0] in the cycle after each of its accepted ops.
  - A last_c_src register records which requester produced the ALU's current carry. Idle and restore cycles set it to NONE, except that a restore sets it to the restored requester.
  - When the grant winner g presents a carry-consuming op and last_c_src != g, the FSM enters RESTORE.
  - RESTORE cycle: req_ready=0; drive op=000, alu_op=0001, s_1=16'hFFFF, s_2={15'b0, saved_c[g]}; the ALU carry becomes saved_c[g]. The winner is held and issued next cycle in ARB; latency is +1 cycle.
- Undefined: no RESTORE state and no saved carry; carry-consuming ops use the ALU's current carry.

Test Plan:
- Single request: r0 issues add 0x1234+0x0001 (op 000/0001) → ready same cycle; next cycle rsp_valid=01, result 0x1235, flags 0000.
- Contention: r0 and r1 valid every cycle with add ops → grants alternate r0,r1,r0,r1; each response appears exactly 1 cycle after its accept.
- Lock chain: r0 issues add 0xFFFF+0x0001 with lock=1, then addc 0x0000+0x0000 with lock=0, while r1 is continuously valid → r1 blocked for both cycles; responses 0x0000 (C=1, Z=1), then 0x0001; r1 granted on the third cycle.
- Carry restore (macro on): r0 add 0xFFFF+1 (C=1 saved), then r1 add 1+1 (C=0), then r0 addc 0+0 → one RESTORE cycle with ready=0, then r0 result 0x0001; with macro off the same sequence gives 0x0000.
- Reset mid-lock: r1 holds the lock, rst_n is pulsed low → locked=0, rsp_valid=0 immediately; after release, r0 and r1 both valid → r0 granted first.
- Idle: no valid for 3 cycles → ALU driven with 000/0001, s_1=s_2=0; alu_flags reads 0010; no rsp_valid.
